fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 30 +++
 rtl/fifo.sv | 81 ++++++++
 tb/tb_fifo.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO slice: pointer arithmetic for arbitrary
// (non power-of-two) depths.
package fifo_pkg;

  // Advance an index by one, wrapping from depth-1 back to 0 by explicit compare.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
    if (idx == depth - 32'd1) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Plain DEPTH x WIDTH storage array: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO with push/pop handshake and
// full/empty status derived from the occupancy count.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_valid,
  input  logic             r_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;
  logic [WIDTH-1:0] head_s;

  // Handshake qualification on the pre-edge flags.
  always_comb begin
    fifo_full  = (count_r == FULL_CNT);
    fifo_empty = (count_r == {CNT_W{1'b0}});
    push_s     = w_valid & ~fifo_full;
    pop_s      = r_ready & ~fifo_empty;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= PTR_W'(wrap_inc(32'(wr_ptr_r), DEPTH));
      end
      if (pop_s) begin
        rd_ptr_r <= PTR_W'(rd_ptr_r == PTR_W'(DEPTH - 1) ? 32'd0 : 32'(rd_ptr_r) + 32'd1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (push_s),
    .waddr(wr_ptr_r),
    .wdata(data_in),
    .raddr(rd_ptr_r),
    .rdata(head_s)
  );

  // Head word is forced to zero while nothing is stored.
  always_comb begin
    if (fifo_empty) begin
      data_out = {WIDTH{1'b0}};
    end else begin
      data_out = head_s;
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed vector table for the corner cases,
// then scoreboard-checked wrap-around, mid-stream reset and random traffic.
module tb_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             w_valid = 1'b0;
  logic             r_ready = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             fifo_full;
  logic             fifo_empty;

  int total = 0;
  int bad = 0;

  logic [WIDTH-1:0] mdl_q [$];

  typedef struct {
    logic             wv;
    logic             rr;
    logic [WIDTH-1:0] din;
    logic             ef;
    logic             ee;
    logic [WIDTH-1:0] ed;
  } vec_t;

  vec_t vecs [16];

  fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_valid   (w_valid),
    .r_ready   (r_ready),
    .data_in   (data_in),
    .data_out  (data_out),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [WIDTH-1:0] exp_d;
    exp_d = (mdl_q.size() > 0) ? mdl_q[0] : '0;
    chk({tag, " data_out"}, data_out, exp_d);
    chk({tag, " full"}, {31'd0, fifo_full}, {31'd0, mdl_q.size() == DEPTH});
    chk({tag, " empty"}, {31'd0, fifo_empty}, {31'd0, mdl_q.size() == 0});
  endtask

  // One clock of scoreboard-checked traffic; inputs driven at posedge+1.
  task automatic cycle(input logic wv, input logic rr, input logic [WIDTH-1:0] din, input string tag);
    bit do_push;
    bit do_pop;
    logic [WIDTH-1:0] exp_w;
    w_valid = wv;
    r_ready = rr;
    data_in = din;
    do_push = wv && (mdl_q.size() < DEPTH);
    do_pop  = rr && (mdl_q.size() > 0);
    if (do_pop) begin
      exp_w = mdl_q.pop_front();
      chk({tag, " popped word"}, data_out, exp_w);
    end
    if (do_push) mdl_q.push_back(din);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    // directed vectors: inputs for one edge, then expected state after it
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_00A0, 1'b0, 1'b0, 32'h0000_00A0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_00A1, 1'b0, 1'b0, 32'h0000_00A0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_00A2, 1'b1, 1'b0, 32'h0000_00A0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_00A3, 1'b1, 1'b0, 32'h0000_00A0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_00A1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_00A2};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_00B0, 1'b0, 1'b0, 32'h0000_00B0};
    vecs[10] = '{1'b1, 1'b1, 32'h0000_00B1, 1'b0, 1'b0, 32'h0000_00B1};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_00B2, 1'b0, 1'b0, 32'h0000_00B1};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_00B3, 1'b1, 1'b0, 32'h0000_00B1};
    vecs[13] = '{1'b1, 1'b1, 32'h0000_00B4, 1'b0, 1'b0, 32'h0000_00B2};
    vecs[14] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_00B3};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};

    // reset state while asserted
    repeat (2) @(posedge clk);
    #1;
    chk("reset empty", {31'd0, fifo_empty}, 32'd1);
    chk("reset full", {31'd0, fifo_full}, 32'd0);
    chk("reset data_out", data_out, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      w_valid = vecs[i].wv;
      r_ready = vecs[i].rr;
      data_in = vecs[i].din;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d full", i), {31'd0, fifo_full}, {31'd0, vecs[i].ef});
      chk($sformatf("vec%0d empty", i), {31'd0, fifo_empty}, {31'd0, vecs[i].ee});
      chk($sformatf("vec%0d data_out", i), data_out, vecs[i].ed);
    end

    // wrap-around streaming with r_ready held high
    mdl_q.delete();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 32'hC000_0000 + i, "stream");
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 32'h0, "drain");

    // mid-stream reset with two words stored
    cycle(1'b1, 1'b0, 32'hD000_0001, "prefill");
    cycle(1'b1, 1'b0, 32'hD000_0002, "prefill");
    w_valid = 1'b0;
    r_ready = 1'b0;
    reset = 1'b0;
    #1;
    chk("async reset empty", {31'd0, fifo_empty}, 32'd1);
    chk("async reset full", {31'd0, fifo_full}, 32'd0);
    chk("async reset data_out", data_out, 32'd0);
    mdl_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, "post reset idle");

    // random traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
